// File: rtl/word_serializer_if.sv
// Handshake and serial-output bundle for word_serializer.
// The slave modport is the serializer; the master modport is the producer or observer.
interface word_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             w;
  logic             w_valid;
  logic             last_bit;
  logic             busy;

  modport slave (
    input  data_in, load_valid,
    output load_ready, w, w_valid, last_bit, busy
  );

  modport master (
    output data_in, load_valid,
    input  load_ready, w, w_valid, last_bit, busy
  );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on valid/ready and shifts
// them out one bit per Clock on w, with an optional idle gap after each word.
module word_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic        IDLE_BIT   = 1'b0
) (
  input  logic               Clock,
  input  logic               Resetn,
  word_serializer_if.slave   bus
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  PENULT   = CW'(WIDTH - 2);
  localparam logic [3:0]     GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam bit             CHAIN    = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic [3:0]       r_gap_cnt;
  logic             r_w;
  logic             r_w_valid;
  logic             r_last_bit;
  logic             r_busy;

  logic             w_last_cycle;
  logic             w_load_ready;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic [WIDTH-1:0] w_shift_rest;

  assign w_last_cycle = (r_state == SHIFT) && (r_bit_cnt == LAST_CNT);
  assign w_load_ready = Resetn && ((r_state == IDLE) || (w_last_cycle && CHAIN));
  assign w_accept     = bus.load_valid && w_load_ready;

  // r_shift holds the bits still to be sent after the one currently on w.
  always_comb begin
    w_first_bit  = 1'b0;
    w_next_bit   = 1'b0;
    w_load_rest  = '0;
    w_shift_rest = '0;
    if (MSB_FIRST) begin
      w_first_bit  = bus.data_in[WIDTH-1];
      w_load_rest  = bus.data_in << 1;
      w_next_bit   = r_shift[WIDTH-1];
      w_shift_rest = r_shift << 1;
    end else begin
      w_first_bit  = bus.data_in[0];
      w_load_rest  = bus.data_in >> 1;
      w_next_bit   = r_shift[0];
      w_shift_rest = r_shift >> 1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_w        <= IDLE_BIT;
      r_w_valid  <= 1'b0;
      r_last_bit <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_accept) begin
      // Acceptance is only possible in IDLE or on a chained last bit, so it
      // takes priority over the per-state transitions below.
      r_state    <= SHIFT;
      r_shift    <= w_load_rest;
      r_bit_cnt  <= '0;
      r_w        <= w_first_bit;
      r_w_valid  <= 1'b1;
      r_last_bit <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_w       <= IDLE_BIT;
          r_w_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
        SHIFT: begin
          if (w_last_cycle) begin
            r_bit_cnt  <= '0;
            r_w        <= IDLE_BIT;
            r_w_valid  <= 1'b0;
            r_last_bit <= 1'b0;
            if (!CHAIN) begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
              r_busy    <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_w        <= w_next_bit;
            r_shift    <= w_shift_rest;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            r_last_bit <= (r_bit_cnt == PENULT);
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_w       <= IDLE_BIT;
          r_w_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.w          = r_w;
  assign bus.w_valid    = r_w_valid;
  assign bus.last_bit   = r_last_bit;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three configurations driven in parallel and checked every
// cycle against a word/bit-count reference model, plus directed stream checks.
module tb_word_serializer;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [7:0] d_in;
  logic       lv;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  word_serializer_if #(.WIDTH(8)) if0 ();
  word_serializer_if #(.WIDTH(8)) if1 ();
  word_serializer_if #(.WIDTH(8)) if2 ();

  assign if0.data_in = d_in;  assign if0.load_valid = lv;
  assign if1.data_in = d_in;  assign if1.load_valid = lv;
  assign if2.data_in = d_in;  assign if2.load_valid = lv;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_BIT(1'b0))
    u_dut0 (.Clock(Clock), .Resetn(Resetn), .bus(if0));
  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_BIT(1'b1))
    u_dut1 (.Clock(Clock), .Resetn(Resetn), .bus(if1));
  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3), .IDLE_BIT(1'b0))
    u_dut2 (.Clock(Clock), .Resetn(Resetn), .bus(if2));

  logic [2:0] s_w, s_valid, s_last, s_ready, s_busy;
  assign s_w     = {if2.w,          if1.w,          if0.w};
  assign s_valid = {if2.w_valid,    if1.w_valid,    if0.w_valid};
  assign s_last  = {if2.last_bit,   if1.last_bit,   if0.last_bit};
  assign s_ready = {if2.load_ready, if1.load_ready, if0.load_ready};
  assign s_busy  = {if2.busy,       if1.busy,       if0.busy};

  localparam bit          P_MSB  [3] = '{1'b1, 1'b0, 1'b1};
  localparam int unsigned P_GAP  [3] = '{0, 0, 3};
  localparam logic        P_IDLE [3] = '{1'b0, 1'b1, 1'b0};

  // Model: bits of the current word still to appear (including this cycle's), gap left.
  int unsigned m_left [3];
  int unsigned m_gap  [3];
  logic [7:0]  m_word [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_ready(int k);
    return Resetn && ((m_left[k] == 0 && m_gap[k] == 0) || (m_left[k] == 1 && P_GAP[k] == 0));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_left[k] = 0;
      m_gap[k]  = 0;
      m_word[k] = '0;
    end
  endtask

  task automatic model_edge();
    if (!Resetn) begin
      model_clear();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (lv && m_ready(k)) begin
          m_word[k] = d_in;
          m_left[k] = 8;
        end else if (m_left[k] > 0) begin
          m_left[k]--;
          if (m_left[k] == 0) m_gap[k] = P_GAP[k];
        end else if (m_gap[k] > 0) begin
          m_gap[k]--;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      logic ew;
      int   idx;
      idx = P_MSB[k] ? int'(m_left[k]) - 1 : 8 - int'(m_left[k]);
      ew  = (m_left[k] > 0) ? m_word[k][idx] : P_IDLE[k];
      check($sformatf("w%0d", k),     32'(s_w[k]),     32'(ew));
      check($sformatf("valid%0d", k), 32'(s_valid[k]), 32'(m_left[k] > 0));
      check($sformatf("last%0d", k),  32'(s_last[k]),  32'(m_left[k] == 1));
      check($sformatf("ready%0d", k), 32'(s_ready[k]), 32'(m_ready(k)));
      check($sformatf("busy%0d", k),  32'(s_busy[k]),  32'(m_left[k] > 0 || m_gap[k] > 0));
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    compare_all();
  endtask

  initial begin
    logic [7:0]  v0, v1;
    logic [15:0] v16;
    logic        allv;
    int          nl, seen, gapn, done;

    Resetn = 1'b1;
    lv     = 1'b0;
    d_in   = '0;
    model_clear();
    #1 Resetn = 1'b0;
    repeat (3) tick();
    Resetn = 1'b1;
    tick();

    // MSB-first / LSB-first shift of 8'hB7
    d_in = 8'hB7; lv = 1'b1;
    tick();
    lv = 1'b0; d_in = 8'h00;
    v0 = '0; v1 = '0; nl = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      v0 = {v0[6:0], s_w[0]};
      v1 = {v1[6:0], s_w[1]};
      nl += int'(s_last[0]);
    end
    check("t1_bits", 32'(v0), 32'h0000_00B7);
    check("t2_bits", 32'(v1), 32'h0000_00ED);
    check("t1_last_count", 32'(nl), 32'd1);
    check("t1_last_on_8", 32'(s_last[0]), 32'd1);
    check("t2_ready_on_8", 32'(s_ready[1]), 32'd1);
    tick();
    check("t1_idle_w", 32'(s_w[0]), 32'd0);
    check("t1_idle_busy", 32'(s_busy[0]), 32'd0);
    repeat (4) tick();

    // Back-to-back chaining with load_valid held high
    d_in = 8'hE0; lv = 1'b1;
    tick();
    d_in = 8'h01;
    v16 = {15'd0, s_w[0]};
    allv = s_valid[0];
    for (int i = 1; i < 16; i++) begin
      tick();
      if (i == 8) lv = 1'b0;
      v16  = {v16[14:0], s_w[0]};
      allv = allv & s_valid[0];
    end
    check("t3_stream", 32'(v16), 32'h0000_E001);
    check("t3_valid_all", 32'(allv), 32'd1);
    repeat (10) tick();

    // Idle gap between words on the GAP_CYCLES=3 instance
    lv = 1'b1; seen = 0; gapn = 0; done = 0;
    for (int i = 0; i < 24; i++) begin
      d_in = 8'($urandom);
      tick();
      if (seen != 0 && done == 0) begin
        if (!s_valid[2] && !s_ready[2] && !s_w[2]) gapn++;
        else done = 1;
      end
      if (s_last[2]) seen = 1;
    end
    check("t4_gap_len", 32'(gapn), 32'd3);
    lv = 1'b0;
    repeat (12) tick();

    // Asynchronous reset in the middle of 8'hFF
    d_in = 8'hFF; lv = 1'b1;
    tick();
    lv = 1'b0;
    repeat (3) tick();
    #2 Resetn = 1'b0;
    #1;
    check("t5_w", 32'(s_w[0]), 32'd0);
    check("t5_valid", 32'(s_valid[0]), 32'd0);
    check("t5_busy", 32'(s_busy[0]), 32'd0);
    check("t5_ready", 32'(s_ready[0]), 32'd0);
    model_clear();
    tick();
    Resetn = 1'b1;
    d_in = 8'h81; lv = 1'b1;
    tick();
    lv = 1'b0; d_in = 8'h00;
    v0 = {7'd0, s_w[0]};
    for (int i = 1; i < 8; i++) begin
      tick();
      v0 = {v0[6:0], s_w[0]};
    end
    check("t5_new_word", 32'(v0), 32'h0000_0081);
    repeat (6) tick();

    // load_valid pulse while not ready is ignored
    d_in = 8'h5A; lv = 1'b1;
    tick();
    lv = 1'b0;
    v0 = {7'd0, s_w[0]};
    for (int i = 1; i < 8; i++) begin
      if (i == 3) begin
        d_in = 8'hC3; lv = 1'b1;
      end
      tick();
      lv = 1'b0;
      v0 = {v0[6:0], s_w[0]};
    end
    check("t6_word", 32'(v0), 32'h0000_005A);
    tick();
    check("t6_no_extra_valid", 32'(s_valid[0]), 32'd0);
    check("t6_no_extra_busy", 32'(s_busy[0]), 32'd0);
    repeat (6) tick();

    // Randomised traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      lv   = ($urandom_range(0, 3) != 0);
      d_in = 8'($urandom);
      if ($urandom_range(0, 96) == 0) begin
        #2 Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
      end else begin
        tick();
      end
    end
    lv = 1'b0;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
